// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for N requesters in front of a shared resource.
//   Each cycle exactly one active requester is granted, or none when no
//   requests are present. Priority rotates to the index after the most recent
//   grant, so a continuously requesting source is never starved.
//
// Ports
//   clk    in   1  single clock, state updates on the rising edge
//   rst_n  in   1  asynchronous, active-low reset
//   req    in   N  request vector, bit i = requester i wants the resource
//   grant  out  N  one-hot grant (all-zero when req == 0), combinational
//
// Handshake
//   There is no valid/ready pairing here: req is sampled every cycle with no
//   hold requirement, and grant is a pure function of req and the stored
//   last-grant register in the same cycle. A requester that drops req simply
//   loses whatever priority it had.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // After reset the top index counts as "last granted", which makes index 0
  // the first one searched.
  localparam logic [N-1:0] LAST_RST = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] last;     // one-hot, most recent grant
  logic [N-1:0] higher;   // bits strictly above the last-granted index
  logic [N-1:0] masked;   // requests that win before wrapping
  logic [N-1:0] pick;     // vector whose lowest set bit is the winner
  logic         seen;

  // Mask + unmasked fallback: requesters above the last grant win first; if
  // none are active the search wraps and the plain lowest request wins.
  always_comb begin
    higher = '0;
    seen   = 1'b0;
    for (int i = 0; i < N; i++) begin
      higher[i] = seen;
      seen      = seen | last[i];
    end
    masked = req & higher;
    pick   = (|masked) ? masked : req;
    // Isolate the lowest set bit; yields zero when pick is zero.
    grant  = pick & (~pick + ONE);
  end

  // Idle cycles leave the rotation point untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= LAST_RST;
    end else if (|req) begin
      last <= grant;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

  localparam int N = 7;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index of the most recent grant.
  int model_last;

  rr_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Search starts one past the last grant and wraps modulo N.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input int last_idx);
    logic [N-1:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (last_idx + k) % N;
      if (r[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic int index_of(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply req, settle, check against the model (and a directed constant
  // when one is given) plus the structural properties.
  task automatic apply(input string tag, input logic [N-1:0] r,
                       input bit use_exp, input logic [N-1:0] exp);
    req = r;
    #1;
    chk({tag, "/model"}, grant, model_grant(r, model_last));
    if (use_exp) chk({tag, "/directed"}, grant, exp);
    chk({tag, "/onehot0"}, {{(N-1){1'b0}}, $onehot0(grant)}, {{(N-1){1'b0}}, 1'b1});
    chk({tag, "/subset"}, grant & ~req, '0);
    chk({tag, "/nonzero"}, {{(N-1){1'b0}}, |grant}, {{(N-1){1'b0}}, |req});
  endtask

  // Advance one clock and update the model exactly as the rules describe.
  task automatic tick();
    logic [N-1:0] g;
    g = model_grant(req, model_last);
    @(posedge clk);
    if (!rst_n) model_last = N - 1;
    else if (req != '0) model_last = index_of(g);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen_cnt [N];
    logic [N-1:0] r;

    rst_n      = 1'b0;
    req        = '0;
    model_last = N - 1;
    #2;

    // Reset with no requests: grant stays zero across several clocks.
    for (int c = 0; c < 3; c++) begin
      apply("rst_idle", 7'b0000000, 1'b1, 7'b0000000);
      tick();
    end
    // Grant under reset reflects req with index 0 first.
    apply("rst_req", 7'b0001010, 1'b1, 7'b0000010);
    tick();
    rst_n = 1'b1;
    #1;
    apply("post_rst", 7'b0001010, 1'b1, 7'b0000010);
    req = '0;
    tick();

    // Rotation after reset (model still at top index since req was idle).
    apply("rot0", 7'b0001010, 1'b1, 7'b0000010); tick();
    apply("rot1", 7'b0001001, 1'b1, 7'b0001000); tick();
    apply("rot2", 7'b0001101, 1'b1, 7'b0000001); tick();
    apply("rot3", 7'b0001101, 1'b1, 7'b0000100); tick();

    // Wrap from the top index.
    apply("top_only", 7'b1000000, 1'b1, 7'b1000000); tick();
    apply("wrap_top", 7'b1000001, 1'b1, 7'b0000001); tick();
    for (int c = 0; c < 3; c++) begin
      apply("single", 7'b1000000, 1'b1, 7'b1000000); tick();
    end

    // Idle cycles preserve the rotation point.
    apply("idle_pre", 7'b0000100, 1'b1, 7'b0000100); tick();
    for (int c = 0; c < 3; c++) begin
      apply("idle", 7'b0000000, 1'b1, 7'b0000000); tick();
    end
    apply("idle_post", 7'b1111111, 1'b1, 7'b0001000); tick();

    // Asynchronous reset mid-operation, between clock edges.
    apply("pre_arst", 7'b1111111, 1'b1, 7'b0010000);
    rst_n = 1'b0;
    model_last = N - 1;
    #1;
    apply("arst", 7'b1111111, 1'b1, 7'b0000001);
    tick();
    rst_n = 1'b1;
    #1;

    // Fairness: all requesting, 14 cycles, each index exactly twice.
    for (int i = 0; i < N; i++) seen_cnt[i] = 0;
    for (int c = 0; c < 2 * N; c++) begin
      logic [N-1:0] e;
      e = '0;
      e[c % N] = 1'b1;
      apply("fair", 7'b1111111, 1'b1, e);
      for (int i = 0; i < N; i++) if (grant[i]) seen_cnt[i]++;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      chk("fair_count", seen_cnt[i][N-1:0], 7'd2);
    end

    // Random traffic, a mix of dense and single-requester patterns.
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = '0;
        r[$urandom_range(0, N - 1)] = 1'b1;
      end else begin
        r = N'($urandom_range(0, (1 << N) - 1));
      end
      apply("rand", r, 1'b0, '0);
      tick();
    end

    req = '0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
